// File: rtl/synth_note_sequencer.sv
// Step sequencer feeding the synth voice: plays a small note pattern at a programmable tempo/gate.
// Build option: define SEQ_LOOP_EN to wrap to step 0 after seq_last instead of stopping (one-shot).
module synth_note_sequencer #(
  parameter int         STEPS         = 8,
  parameter int         PRESCALE      = 256,
  parameter logic [7:0] DEFAULT_COUNT = 8'd66,
  localparam int        AW            = $clog2(STEPS),
  localparam int        PW            = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] seq_last,
  input  logic [7:0]    step_len,
  input  logic [7:0]    gate_len,
  output logic          trig,
  output logic [7:0]    osc_count,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          step_strobe
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [7:0]      tick_reg, tick_next;
  logic [AW-1:0]   step_idx_reg, step_idx_next;
  logic [7:0]      osc_count_reg, osc_count_next;
  logic            trig_reg, trig_next;
  logic            busy_reg, busy_next;
  logic            strobe_reg, strobe_next;
  logic [7:0]      mem_reg [STEPS];

  logic [7:0]      step_eff;
  logic            presc_wrap;
  logic            presc_last2;
  logic [8:0]      tick_p1;
  logic            step_end;
  logic            gate_end;
  logic            last_step;
  logic            load_en;
  logic [AW-1:0]   load_idx;
  logic [7:0]      entry;
  logic [6:0]      note;

  // Pattern store; a load in the same cycle as a write reads the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_reg[i] <= {1'b0, DEFAULT_COUNT[6:0]};
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    step_eff    = (step_len == 8'd0) ? 8'd1 : step_len;
    presc_wrap  = (presc_reg == PW'(PRESCALE - 1));
    presc_last2 = (presc_reg == PW'(PRESCALE - 2));
    tick_p1     = {1'b0, tick_reg} + 9'd1;
    step_end    = presc_wrap && (tick_p1 >= {1'b0, step_eff});
    // A gate covering the whole step still drops for the final clk cycle so the ADSR retriggers.
    if (gate_len < step_eff) begin
      gate_end = presc_wrap && (tick_p1 >= {1'b0, gate_len});
    end else begin
      gate_end = presc_last2 && (tick_p1 >= {1'b0, step_eff});
    end
    last_step = (step_idx_reg >= seq_last);
  end

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    tick_next      = tick_reg;
    step_idx_next  = step_idx_reg;
    osc_count_next = osc_count_reg;
    trig_next      = trig_reg;
    busy_next      = busy_reg;
    strobe_next    = 1'b0;
    load_en        = 1'b0;
    load_idx       = '0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          load_en = 1'b1;
        end
      end
      GATE, HOLD: begin
        if (stop) begin
          state_next = IDLE;
          trig_next  = 1'b0;
          busy_next  = 1'b0;
        end else if (start) begin
          load_en = 1'b1;
        end else if (step_end) begin
          if (last_step && !LOOP_EN) begin
            state_next = IDLE;
            trig_next  = 1'b0;
            busy_next  = 1'b0;
          end else begin
            load_en  = 1'b1;
            load_idx = last_step ? '0 : step_idx_reg + 1'b1;
          end
        end else begin
          presc_next = presc_wrap ? '0 : presc_reg + 1'b1;
          tick_next  = presc_wrap ? tick_reg + 8'd1 : tick_reg;
          if (state_reg == GATE && gate_end) begin
            trig_next = 1'b0;
            if (gate_len < step_eff) begin
              state_next = HOLD;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        trig_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    entry = mem_reg[load_idx];
    note  = (entry[6:0] == 7'd0) ? 7'd1 : entry[6:0];

    if (load_en) begin
      state_next     = GATE;
      presc_next     = '0;
      tick_next      = 8'd0;
      step_idx_next  = load_idx;
      osc_count_next = {1'b0, note};
      trig_next      = !entry[7] && (gate_len != 8'd0);
      busy_next      = 1'b1;
      strobe_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      tick_reg      <= 8'd0;
      step_idx_reg  <= '0;
      osc_count_reg <= DEFAULT_COUNT;
      trig_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      strobe_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      tick_reg      <= tick_next;
      step_idx_reg  <= step_idx_next;
      osc_count_reg <= osc_count_next;
      trig_reg      <= trig_next;
      busy_reg      <= busy_next;
      strobe_reg    <= strobe_next;
    end
  end

  assign trig        = trig_reg;
  assign osc_count   = osc_count_reg;
  assign busy        = busy_reg;
  assign step_idx    = step_idx_reg;
  assign step_strobe = strobe_reg;

endmodule

// File: tb/tb_synth_note_sequencer.sv
// Scoreboard bench for synth_note_sequencer (PRESCALE=4, STEPS=8): expected step loads are queued
// when stimulus is driven and compared on every step_strobe; per-play cycle counts are checked directly.
module tb_synth_note_sequencer;

  localparam int STEPS    = 8;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] seq_last;
  logic [7:0] step_len, gate_len;
  logic       trig;
  logic [7:0] osc_count;
  logic       busy;
  logic [2:0] step_idx;
  logic       step_strobe;

  int compared   = 0;
  int mismatched = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;

  int busy_cyc, trig_cyc, low_cyc;
  int hist[256];

  synth_note_sequencer #(.STEPS(STEPS), .PRESCALE(PRESCALE), .DEFAULT_COUNT(8'd66)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_last(seq_last), .step_len(step_len), .gate_len(gate_len),
    .trig(trig), .osc_count(osc_count), .busy(busy),
    .step_idx(step_idx), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Scoreboard consumer: every step load must match the next queued {step_idx, osc_count, trig}.
  always @(negedge clk) begin
    if (rst_n && step_strobe) begin
      if (exp_q.size() == 0) begin
        check("strobe_extra", {31'd0, step_strobe}, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("strobe", {20'd0, step_idx, osc_count, trig}, {20'd0, exp_e});
      end
    end
  end

  task automatic push(input int idx, input int osc, input bit t);
    exp_q.push_back({3'(idx), 8'(osc), t});
  endtask

  task automatic write_entry(input int addr, input int data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 8'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_stop(input string tag);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check({tag, "_trig"}, {31'd0, trig}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Start (restarting if already busy) and profile the play until busy falls, bounded by limit cycles.
  task automatic play(input int limit);
    busy_cyc = 0; trig_cyc = 0; low_cyc = 0;
    for (int i = 0; i < 256; i++) hist[i] = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < limit && busy; i++) begin
      busy_cyc++;
      if (trig) trig_cyc++; else low_cyc++;
      hist[osc_count]++;
      @(negedge clk);
    end
    check("play_done_busy", {31'd0, busy}, 32'd0);
    check("play_done_trig", {31'd0, trig}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; seq_last = '0; step_len = 8'd1; gate_len = 8'd1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_osc", {24'd0, osc_count}, 32'd66);
    check("rst_idx", {29'd0, step_idx}, 32'd0);
    check("rst_strobe", {31'd0, step_strobe}, 32'd0);

    // Default pattern readback through a play of step 0.
    seq_last = 3'd0; step_len = 8'd3; gate_len = 8'd1;
    push(0, 66, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("readback_busy", {31'd0, busy}, 32'd1);
    check("readback_osc", {24'd0, osc_count}, 32'd66);
    pulse_stop("readback_stop");

    write_entry(0, 10);
    write_entry(1, 20);
    write_entry(2, 30);

    // Start and stop together while idle: stop wins, nothing loads.
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_busy", {31'd0, busy}, 32'd0);
    check("startstop_strobe", {31'd0, step_strobe}, 32'd0);

`ifdef SEQ_LOOP_EN
    seq_last = 3'd1; step_len = 8'd1; gate_len = 8'd1;
    push(0, 10, 1'b1); push(1, 20, 1'b1); push(0, 10, 1'b1); push(1, 20, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    check("loop_busy", {31'd0, busy}, 32'd1);
    check("loop_idx", {29'd0, step_idx}, 32'd1);
    pulse_stop("loop_stop");
`else
    // Three-step one-shot, short gate.
    seq_last = 3'd2; step_len = 8'd3; gate_len = 8'd1;
    push(0, 10, 1'b1); push(1, 20, 1'b1); push(2, 30, 1'b1);
    play(200);
    check("p1_busy_cycles", busy_cyc, 36);
    check("p1_trig_cycles", trig_cyc, 12);
    check("p1_osc10", hist[10], 12);
    check("p1_osc20", hist[20], 12);
    check("p1_osc30", hist[30], 12);

    // Gate longer than step: one low cycle at the end of each step.
    gate_len = 8'd5;
    push(0, 10, 1'b1); push(1, 20, 1'b1); push(2, 30, 1'b1);
    play(200);
    check("p2_busy_cycles", busy_cyc, 36);
    check("p2_low_cycles", low_cyc, 3);

    // Rest on step 1 silences that step but still updates osc_count.
    write_entry(1, 8'h94);
    push(0, 10, 1'b1); push(1, 20, 1'b0); push(2, 30, 1'b1);
    play(200);
    check("p3_trig_cycles", trig_cyc, 22);
    check("p3_low_cycles", low_cyc, 14);
    check("p3_osc20", hist[20], 12);
    write_entry(1, 20);

    // Mid-step write to the sounding entry, then restart while busy.
    gate_len = 8'd1;
    push(0, 10, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd44;
    @(negedge clk); wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("midwrite_osc_hold", {24'd0, osc_count}, 32'd10);
    push(0, 44, 1'b1); push(1, 20, 1'b1); push(2, 30, 1'b1);
    play(200);
    check("p4_busy_cycles", busy_cyc, 36);
    check("p4_osc44", hist[44], 12);

    // Zero note is played as half-period 1.
    write_entry(3, 8'h00);
    seq_last = 3'd3;
    push(0, 44, 1'b1); push(1, 20, 1'b1); push(2, 30, 1'b1); push(3, 1, 1'b1);
    play(200);
    check("p5_osc_last_held", {24'd0, osc_count}, 32'd1);
    seq_last = 3'd2;
`endif

    // Same-cycle write and load of entry 0: the load sees the old value.
    write_entry(0, 44);
    push(0, 44, 1'b1);
    @(negedge clk); start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd55;
    @(negedge clk); start = 1'b0; wr_en = 1'b0;
    check("samecycle_osc", {24'd0, osc_count}, 32'd44);
    pulse_stop("samecycle_stop");

    // Asynchronous reset in the middle of a gate.
    step_len = 8'd3; gate_len = 8'd5;
    push(0, 55, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("prereset_trig", {31'd0, trig}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_trig", {31'd0, trig}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_osc", {24'd0, osc_count}, 32'd66);
    check("async_strobe", {31'd0, step_strobe}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postreset_busy", {31'd0, busy}, 32'd0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
